// File: rtl/uart_frame_rx_if.sv
// Signal bundle between a UART serial source and the two-byte frame receiver.
// The master drives the serial line; the slave (receiver) drives the decoded frame.
interface uart_frame_rx_if;
    logic       rx;
    logic [7:0] comida;
    logic [7:0] agua;
    logic       valid;
    logic       ferr;
    logic [1:0] stat;

    modport master (
        output rx,
        input  comida,
        input  agua,
        input  valid,
        input  ferr,
        input  stat
    );

    modport slave (
        input  rx,
        output comida,
        output agua,
        output valid,
        output ferr,
        output stat
    );
endinterface

// File: rtl/uart_frame_rx.sv
// Two-byte UART frame receiver (8N1, LSB first). Byte 0 is food (comida),
// byte 1 is water (agua); both are published together once byte 1 arrives.
//
// Bit receiver states
//   state    | meaning
//   RX_IDLE  | waiting for a falling edge on the synchronized line
//   RX_START | half a bit in, confirming the start bit is still low
//   RX_DATA  | sampling 8 data bits, one per bit time
//   RX_STOP  | sampling the stop bit
//
// Frame states (value is driven on stat)
//   state    | meaning
//   FR_EXP0  | 0: expecting byte 0
//   FR_RX0   | 1: receiving byte 0
//   FR_EXP1  | 2: byte 0 held, expecting byte 1 (timeout running)
//   FR_RX1   | 3: receiving byte 1
module uart_frame_rx #(
    parameter int BAUD    = 104,
    parameter int TIMEOUT = 1664
) (
    input  logic           clk,
    input  logic           rst,
    uart_frame_rx_if.slave bus
);
    localparam int CW = $clog2(BAUD + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] C_BAUD = CW'(BAUD);
    localparam logic [CW-1:0] C_HALF = CW'(BAUD / 2);
    localparam logic [CW-1:0] C_ONE  = CW'(1);
    localparam logic [TW-1:0] T_TOUT = TW'(TIMEOUT);
    localparam logic [TW-1:0] T_ONE  = TW'(1);

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    typedef enum logic [1:0] {
        FR_EXP0 = 2'd0,
        FR_RX0  = 2'd1,
        FR_EXP1 = 2'd2,
        FR_RX1  = 2'd3
    } fr_state_t;

    logic          r_rx_meta;
    logic          r_rx_sync;
    logic          r_rx_prev;
    rx_state_t     r_rx_state;
    rx_state_t     w_rx_next;
    fr_state_t     r_fr_state;
    fr_state_t     w_fr_next;
    logic [CW-1:0] r_bit_tmr;
    logic [2:0]    r_bits_left;
    logic [7:0]    r_shift;
    logic [7:0]    r_byte0;
    logic [TW-1:0] r_to_tmr;
    logic [7:0]    r_comida;
    logic [7:0]    r_agua;
    logic          r_valid;
    logic          r_ferr;

    logic w_fall;
    logic w_bit_tc;
    logic w_timeout;
    logic w_start_det;
    logic w_false_start;
    logic w_data_smp;
    logic w_byte_ok;
    logic w_frame_err;

    // Two-flop synchronizer plus one history flop for falling-edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= bus.rx;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;
        end
    end

    // State registers for the bit receiver and the frame sequencer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_state <= RX_IDLE;
            r_fr_state <= FR_EXP0;
        end else begin
            r_rx_state <= w_rx_next;
            r_fr_state <= w_fr_next;
        end
    end

    // Next-state logic and per-cycle receiver events.
    always_comb begin
        w_rx_next     = r_rx_state;
        w_fr_next     = r_fr_state;
        w_start_det   = 1'b0;
        w_false_start = 1'b0;
        w_data_smp    = 1'b0;
        w_byte_ok     = 1'b0;
        w_frame_err   = 1'b0;
        w_fall        = r_rx_prev & ~r_rx_sync;
        w_bit_tc      = (r_bit_tmr == C_ONE);
        w_timeout     = (r_fr_state == FR_EXP1) && (r_to_tmr == T_ONE);

        case (r_rx_state)
            RX_IDLE: begin
                if (w_fall) begin
                    w_start_det = 1'b1;
                    w_rx_next   = RX_START;
                end
            end
            RX_START: begin
                if (w_bit_tc) begin
                    if (!r_rx_sync) begin
                        w_rx_next = RX_DATA;
                    end else begin
                        w_false_start = 1'b1;
                        w_rx_next     = RX_IDLE;
                    end
                end
            end
            RX_DATA: begin
                if (w_bit_tc) begin
                    w_data_smp = 1'b1;
                    if (r_bits_left == 3'd0) begin
                        w_rx_next = RX_STOP;
                    end
                end
            end
            default: begin
                if (w_bit_tc) begin
                    w_rx_next = RX_IDLE;
                    if (r_rx_sync) begin
                        w_byte_ok = 1'b1;
                    end else begin
                        w_frame_err = 1'b1;
                    end
                end
            end
        endcase

        case (r_fr_state)
            FR_EXP0: begin
                if (w_start_det) w_fr_next = FR_RX0;
            end
            FR_RX0: begin
                if (w_byte_ok) begin
                    w_fr_next = FR_EXP1;
                end else if (w_false_start || w_frame_err) begin
                    w_fr_next = FR_EXP0;
                end
            end
            FR_EXP1: begin
                // An expiring timeout takes precedence; a simultaneous start becomes byte 0.
                if (w_timeout) begin
                    w_fr_next = w_start_det ? FR_RX0 : FR_EXP0;
                end else if (w_start_det) begin
                    w_fr_next = FR_RX1;
                end
            end
            default: begin
                if (w_byte_ok || w_frame_err) begin
                    w_fr_next = FR_EXP0;
                end else if (w_false_start) begin
                    w_fr_next = FR_EXP1;
                end
            end
        endcase
    end

    // Bit timer, bit counter and LSB-first shift register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bit_tmr   <= '0;
            r_bits_left <= '0;
            r_shift     <= '0;
        end else begin
            if (w_start_det) begin
                r_bit_tmr <= C_HALF;
            end else if (r_rx_state != RX_IDLE) begin
                r_bit_tmr <= w_bit_tc ? C_BAUD : r_bit_tmr - C_ONE;
            end
            if (w_start_det) begin
                r_bits_left <= 3'd7;
            end else if (w_data_smp && (r_bits_left != 3'd0)) begin
                r_bits_left <= r_bits_left - 3'd1;
            end
            if (w_data_smp) begin
                r_shift <= {r_rx_sync, r_shift[7:1]};
            end
        end
    end

    // Inter-byte timeout: reloaded outside state 2, counts down while waiting for byte 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_to_tmr <= '0;
        end else if (r_fr_state != FR_EXP1) begin
            r_to_tmr <= T_TOUT;
        end else if (r_to_tmr != '0) begin
            r_to_tmr <= r_to_tmr - T_ONE;
        end
    end

    // Byte-0 holding register and the published frame outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_byte0  <= '0;
            r_comida <= '0;
            r_agua   <= '0;
            r_valid  <= 1'b0;
            r_ferr   <= 1'b0;
        end else begin
            if ((r_fr_state == FR_RX0) && w_byte_ok) begin
                r_byte0 <= r_shift;
            end else if (w_timeout || w_frame_err) begin
                r_byte0 <= '0;
            end
            r_valid <= (r_fr_state == FR_RX1) && w_byte_ok;
            r_ferr  <= w_frame_err;
            if ((r_fr_state == FR_RX1) && w_byte_ok) begin
                r_comida <= r_byte0;
                r_agua   <= r_shift;
            end
        end
    end

    assign bus.comida = r_comida;
    assign bus.agua   = r_agua;
    assign bus.valid  = r_valid;
    assign bus.ferr   = r_ferr;
    assign bus.stat   = r_fr_state;
endmodule

// File: tb/tb_uart_frame_rx.sv
// Bench for uart_frame_rx: directed serial stimulus, a frame-level model that
// predicts which byte pairs and framing errors must appear, and a per-cycle
// compare process checking pulses and held outputs against that model.
module tb_uart_frame_rx;
    localparam int BAUD    = 104;
    localparam int TIMEOUT = 1664;

    logic clk = 1'b0;
    logic rst = 1'b1;

    uart_frame_rx_if bus ();

    uart_frame_rx #(.BAUD(BAUD), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int n_valid = 0;
    int n_ferr = 0;

    logic [15:0] exp_q[$];
    logic        m_holding = 1'b0;
    logic [7:0]  m_byte0 = 8'h00;
    logic [7:0]  m_comida = 8'h00;
    logic [7:0]  m_agua = 8'h00;
    int          m_ferr_pend = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level model: a good byte is either held as byte 0 or completes a pair.
    task automatic model_byte(input logic [7:0] d, input logic good);
        if (!good) begin
            m_ferr_pend++;
            m_holding = 1'b0;
        end else if (m_holding) begin
            exp_q.push_back({m_byte0, d});
            m_holding = 1'b0;
        end else begin
            m_holding = 1'b1;
            m_byte0   = d;
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_holding   = 1'b0;
        m_comida    = 8'h00;
        m_agua      = 8'h00;
        m_ferr_pend = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
        if (m_holding && n >= TIMEOUT) m_holding = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic good);
        model_byte(d, good);
        bus.rx = 1'b0;
        repeat (BAUD) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            bus.rx = d[i];
            repeat (BAUD) @(negedge clk);
        end
        bus.rx = good;
        repeat (BAUD) @(negedge clk);
        bus.rx = 1'b1;
    endtask

    // Per-cycle comparison of DUT outputs against the model.
    always @(negedge clk) begin
        check("valid_ferr_exclusive", {15'd0, bus.valid & bus.ferr}, 16'd0);
        if (bus.valid) begin
            n_valid++;
            if (exp_q.size() == 0) begin
                check("unexpected_valid", {15'd0, bus.valid}, 16'd0);
            end else begin
                logic [15:0] p;
                p = exp_q.pop_front();
                check("pair_comida", {8'h00, bus.comida}, {8'h00, p[15:8]});
                check("pair_agua", {8'h00, bus.agua}, {8'h00, p[7:0]});
                m_comida = p[15:8];
                m_agua   = p[7:0];
            end
        end else begin
            check("hold_comida", {8'h00, bus.comida}, {8'h00, m_comida});
            check("hold_agua", {8'h00, bus.agua}, {8'h00, m_agua});
        end
        if (bus.ferr) begin
            n_ferr++;
            if (m_ferr_pend == 0) begin
                check("unexpected_ferr", {15'd0, bus.ferr}, 16'd0);
            end else begin
                m_ferr_pend--;
            end
        end
    end

    initial begin
        bus.rx = 1'b1;
        rst    = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_stat", {14'd0, bus.stat}, 16'd0);
        check("rst_valid", {15'd0, bus.valid}, 16'd0);
        check("rst_ferr", {15'd0, bus.ferr}, 16'd0);
        check("rst_comida", {8'h00, bus.comida}, 16'h0000);
        rst = 1'b0;
        idle(20);

        // Basic frame
        send_byte(8'h7B, 1'b1);
        send_byte(8'h7D, 1'b1);
        idle(20);
        check("s1_comida", {8'h00, bus.comida}, 16'h007B);
        check("s1_agua", {8'h00, bus.agua}, 16'h007D);
        check("s1_stat", {14'd0, bus.stat}, 16'd0);
        check("s1_nvalid", 16'(n_valid), 16'd1);
        check("s1_nferr", 16'(n_ferr), 16'd0);

        // Short glitch: false start
        bus.rx = 1'b0;
        repeat (15) @(negedge clk);
        check("s2_stat_glitch", {14'd0, bus.stat}, 16'd1);
        repeat (5) @(negedge clk);
        bus.rx = 1'b1;
        idle(2 * BAUD);
        check("s2_stat_after", {14'd0, bus.stat}, 16'd0);
        check("s2_nvalid", 16'(n_valid), 16'd1);
        check("s2_nferr", 16'(n_ferr), 16'd0);

        // Framing error, then recovery
        send_byte(8'h55, 1'b0);
        idle(2 * BAUD);
        check("s3_nferr", 16'(n_ferr), 16'd1);
        check("s3_stat", {14'd0, bus.stat}, 16'd0);
        send_byte(8'h01, 1'b1);
        send_byte(8'h02, 1'b1);
        idle(20);
        check("s3_comida", {8'h00, bus.comida}, 16'h0001);
        check("s3_agua", {8'h00, bus.agua}, 16'h0002);
        check("s3_nvalid", 16'(n_valid), 16'd2);

        // Inter-byte timeout
        send_byte(8'h33, 1'b1);
        check("s4_stat_wait", {14'd0, bus.stat}, 16'd2);
        idle(TIMEOUT + 10);
        check("s4_stat_timeout", {14'd0, bus.stat}, 16'd0);
        check("s4_comida_kept", {8'h00, bus.comida}, 16'h0001);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        idle(20);
        check("s4_comida", {8'h00, bus.comida}, 16'h0011);
        check("s4_agua", {8'h00, bus.agua}, 16'h0022);
        check("s4_nvalid", 16'(n_valid), 16'd3);

        // Reset during byte 1 of a frame
        send_byte(8'h7B, 1'b1);
        send_byte(8'h7D, 1'b1);
        idle(20);
        check("s5_nvalid_pre", 16'(n_valid), 16'd4);
        send_byte(8'h44, 1'b1);
        bus.rx = 1'b0;
        repeat (BAUD) @(negedge clk);
        bus.rx = 1'b1;
        repeat (3 * BAUD) @(negedge clk);
        check("s5_stat_byte1", {14'd0, bus.stat}, 16'd3);
        #2;
        model_reset();
        rst = 1'b1;
        #1;
        check("s5_async_comida", {8'h00, bus.comida}, 16'h0000);
        check("s5_async_agua", {8'h00, bus.agua}, 16'h0000);
        check("s5_async_stat", {14'd0, bus.stat}, 16'd0);
        repeat (5) @(negedge clk);
        rst = 1'b0;
        idle(2 * BAUD);
        send_byte(8'hA0, 1'b1);
        send_byte(8'h0A, 1'b1);
        idle(20);
        check("s5_comida", {8'h00, bus.comida}, 16'h00A0);
        check("s5_agua", {8'h00, bus.agua}, 16'h000A);
        check("s5_nvalid", 16'(n_valid), 16'd5);

        // Three frames back to back, no idle gap
        send_byte(8'hC1, 1'b1);
        send_byte(8'h1C, 1'b1);
        send_byte(8'hE7, 1'b1);
        send_byte(8'h80, 1'b1);
        send_byte(8'h0F, 1'b1);
        send_byte(8'hF0, 1'b1);
        idle(20);
        check("s6_nvalid", 16'(n_valid), 16'd8);
        check("s6_comida", {8'h00, bus.comida}, 16'h000F);
        check("s6_agua", {8'h00, bus.agua}, 16'h00F0);
        check("s6_stat", {14'd0, bus.stat}, 16'd0);
        check("end_queue_drained", 16'(exp_q.size()), 16'd0);
        check("end_nferr", 16'(n_ferr), 16'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_frame_rx.md
UART_FRAME_RX -- requirements
Module: uart_frame_rx

Interface
REQ-001 Parameter BAUD, default 104 (`B115200 at 12 MHz), meaning clock cycles per UART bit; legal range 8 or greater.
REQ-002 Parameter TIMEOUT, default 1664 (16 bit-times), meaning the maximum number of clocks allowed from the byte-0 stop sample to the byte-1 start-bit detection.
REQ-003 clk  input  1  system clock; all state is updated on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 rx  input  1  serial line, asynchronous to clk, idle high, 8N1 format, LSB first.
REQ-006 comida  output  8  food byte of the last valid frame.
REQ-007 agua  output  8  water byte of the last valid frame.
REQ-008 valid  output  1  one-cycle pulse when comida and agua are updated.
REQ-009 ferr  output  1  one-cycle pulse on a framing error (stop bit sampled low).
REQ-010 stat  output  2  frame state: 0 = expecting byte 0, 1 = receiving byte 0, 2 = expecting byte 1, 3 = receiving byte 1.

Function
REQ-011 rx SHALL pass through a two-flop synchronizer; all decoding SHALL use the synchronized value only.
REQ-012 The bit receiver SHALL use the states IDLE, START, DATA and STOP.
REQ-013 In IDLE, a high-to-low transition of synchronized rx SHALL enter START and load the bit counter with BAUD/2.
REQ-014 In START, rx is sampled when the counter expires: low -> DATA with the counter at BAUD; high -> IDLE (false start), with no ferr and no byte.
REQ-015 In DATA, 8 samples SHALL be taken, one every BAUD clocks, shifted in LSB first; after the 8th sample the receiver SHALL enter STOP.
REQ-016 In STOP, rx is sampled after BAUD clocks: high -> byte accepted; low -> byte discarded and ferr pulsed on the next edge. Either way the receiver SHALL return to IDLE.
REQ-017 The frame FSM SHALL follow the stat encoding of REQ-010:
- 0 -> 1 on start detection.
- 1 -> 2 on an accepted byte, storing it as byte 0.
- 2 -> 3 on start detection.
- 3 -> 0 on an accepted byte.
REQ-018 A false start in state 1 SHALL return the FSM to 0; a false start in state 3 SHALL return it to 2.
REQ-019 A framing error in state 1 or state 3 SHALL return the FSM to 0 and discard any held byte 0.
REQ-020 On the byte-1 acceptance edge + 1, comida SHALL take the stored byte 0, agua SHALL take byte 1, and valid SHALL be 1 for exactly one cycle.
REQ-021 comida and agua SHALL hold their values between valid frames.
REQ-022 In state 2, a timeout counter SHALL count clocks; on reaching TIMEOUT the FSM SHALL return to 0 and discard byte 0, with no ferr.
REQ-023 If the timeout expires on the same edge as a start detection, the timeout wins, and the incoming byte SHALL be treated as byte 0 (stat 0 -> 1).
REQ-024 valid and ferr SHALL never be asserted in the same cycle.
REQ-025 Back-to-back frames with zero idle time between the stop bit and the next start bit SHALL all be decoded.

Reset
REQ-026 While rst = 1, the block SHALL hold: comida = 0, agua = 0, valid = 0, ferr = 0, stat = 0, receiver in IDLE, all counters cleared, synchronizer flops set to 1.
REQ-027 Reset asserted mid-byte or mid-frame SHALL abort the partial byte/frame with no valid or ferr pulse.
REQ-028 After reset release, the first high-to-low edge of rx SHALL begin byte 0.

Verification
REQ-029 Scenario: after reset, send 0x7B then 0x7D at BAUD = 104 -> a single valid pulse, comida = 0x7B, agua = 0x7D, stat returns to 0, ferr stays 0.
REQ-030 Scenario: drive rx low for 20 clocks, then high -> no valid, no ferr, stat is 1 during the glitch and returns to 0, outputs unchanged.
REQ-031 Scenario: send 0x55 with its stop bit low -> ferr pulses for 1 cycle, stat = 0, no valid; then send 0x01 and 0x02 -> comida = 0x01, agua = 0x02.
REQ-032 Scenario: send 0x33, then idle for TIMEOUT + 10 clocks -> stat goes 2 -> 0 with no output change; then send 0x11 and 0x22 -> comida = 0x11, agua = 0x22.
REQ-033 Scenario: after a valid frame (0x7B, 0x7D), assert rst during byte 1 of the next frame -> comida = agua = 0 and stat = 0 immediately (asynchronously); then send 0xA0 and 0x0A -> comida = 0xA0, agua = 0x0A.
REQ-034 Scenario: send three frames back-to-back with no idle gap -> exactly three valid pulses, each carrying the correct byte pair.
